// File: rtl/fir_2d_kernel_pkg.sv
// Shared constants, control bundle and output rounding helper for the 5x5 FIR kernel.
package fir_2d_kernel_pkg;

  localparam int KSIZE      = 5;
  localparam int NTAP       = 25;
  localparam int CENTER_IDX = 12;
  localparam int ACC_W      = 22;
  localparam int LAT        = 7;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } ctrl_t;

  // Round-half-up then arithmetic right shift of the accumulated sum.
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] acc,
    input logic [3:0]              sh
  );
    logic signed [ACC_W-1:0] bias;
    if (sh == 4'd0) begin
      bias = '0;
    end else begin
      bias = $signed({{(ACC_W-1){1'b0}}, 1'b1} << (sh - 4'd1));
    end
    return (acc + bias) >>> sh;
  endfunction

endpackage

// File: rtl/fir_row_mac.sv
// One window row: five unsigned pixels times five signed taps, registered
// products followed by a registered row sum.
module fir_row_mac
  import fir_2d_kernel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KSIZE-1:0][PIX_W-1:0]   pix,
  input  logic [KSIZE-1:0][COEF_W-1:0]  coef,
  output logic signed [ACC_W-1:0]       sum
);

  localparam int PROD_W = PIX_W + COEF_W + 1;

  logic signed [PROD_W-1:0] prod_r [KSIZE];
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  sum_r;

  // Product stage; the pixel gets a zero sign bit so it stays non-negative.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KSIZE; i++) prod_r[i] <= '0;
    end else begin
      for (int i = 0; i < KSIZE; i++) begin
        prod_r[i] <= PROD_W'($signed({1'b0, pix[i]})) * PROD_W'($signed(coef[i]));
      end
    end
  end

  // Sign-extended sum of the five products.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < KSIZE; i++) sum_s = sum_s + ACC_W'(prod_r[i]);
  end

  // Row-sum stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= '0;
    end else begin
      sum_r <= sum_s;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/fir_2d_kernel.sv
// 5x5 streaming 2D FIR: window, products, row sums, total, clamped output.
// Coefficients and shift are double-buffered and swap on the vs_i rising edge.
module fir_2d_kernel
  import fir_2d_kernel_pkg::*;
#(
  parameter int COEF_W = 8,
  parameter int PIX_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         p0,
  input  logic [PIX_W-1:0]         p1,
  input  logic [PIX_W-1:0]         p2,
  input  logic [PIX_W-1:0]         p3,
  input  logic [PIX_W-1:0]         p4,
  input  logic                     dv_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  input  logic                     coef_we,
  input  logic [4:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [3:0]               shift_i,
  output logic [PIX_W-1:0]         y_o,
  output logic                     dv_o,
  output logic                     hs_o,
  output logic                     vs_o
);

  logic [KSIZE-1:0][PIX_W-1:0]  col_s;
  logic [PIX_W-1:0]             win_r [KSIZE][KSIZE];
  logic signed [COEF_W-1:0]     coef_sh_r  [NTAP];
  logic signed [COEF_W-1:0]     coef_act_r [NTAP];
  logic [3:0]                   shift_sh_r;
  logic [3:0]                   shift_act_r;
  logic                         vs_prev_r;
  logic                         vs_rise_s;
  logic [KSIZE-1:0][PIX_W-1:0]  row_pix_s  [KSIZE];
  logic [KSIZE-1:0][COEF_W-1:0] row_coef_s [KSIZE];
  logic signed [ACC_W-1:0]      row_sum_s  [KSIZE];
  logic signed [ACC_W-1:0]      total_s;
  logic signed [ACC_W-1:0]      total_r;
  logic signed [ACC_W-1:0]      rnd_s;
  logic [PIX_W-1:0]             y_s;
  logic [PIX_W-1:0]             y_r;
  ctrl_t                        ctrl_r [LAT];

  assign col_s     = {p4, p3, p2, p1, p0};
  assign vs_rise_s = vs_i & ~vs_prev_r;

  // Window shift: [row][col], column 0 newest, column 4 oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win_r[r][c] <= '0;
    end else begin
      for (int r = 0; r < KSIZE; r++) begin
        win_r[r][0] <= col_s[r];
        for (int c = 1; c < KSIZE; c++) win_r[r][c] <= win_r[r][c-1];
      end
    end
  end

  // Shadow/active coefficient bank; the copy takes the pre-write shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) begin
        coef_sh_r[i]  <= (i == CENTER_IDX) ? COEF_W'(1) : '0;
        coef_act_r[i] <= (i == CENTER_IDX) ? COEF_W'(1) : '0;
      end
      shift_sh_r  <= 4'd0;
      shift_act_r <= 4'd0;
      vs_prev_r   <= 1'b0;
    end else begin
      vs_prev_r  <= vs_i;
      shift_sh_r <= shift_i;
      if (vs_rise_s) begin
        coef_act_r  <= coef_sh_r;
        shift_act_r <= shift_sh_r;
      end
      if (coef_we && (coef_addr < 5'd25)) begin
        coef_sh_r[coef_addr] <= coef_data;
      end
    end
  end

  // Regroup window and active taps per row for the row MACs.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        row_pix_s[r][c]  = win_r[r][c];
        row_coef_s[r][c] = coef_act_r[r*KSIZE + c];
      end
    end
  end

  for (genvar g = 0; g < KSIZE; g++) begin : g_row
    fir_row_mac #(
      .PIX_W  (PIX_W),
      .COEF_W (COEF_W)
    ) u_row_mac (
      .clk  (clk),
      .rst  (rst),
      .pix  (row_pix_s[g]),
      .coef (row_coef_s[g]),
      .sum  (row_sum_s[g])
    );
  end

  // Sum of the five registered row sums.
  always_comb begin
    total_s = '0;
    for (int r = 0; r < KSIZE; r++) total_s = total_s + row_sum_s[r];
  end

  // Total stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_r <= '0;
    end else begin
      total_r <= total_s;
    end
  end

  // Round, shift and clamp to the unsigned pixel range.
  always_comb begin
    rnd_s = round_shift(total_r, shift_act_r);
    if (rnd_s[ACC_W-1]) begin
      y_s = '0;
    end else if (|rnd_s[ACC_W-2:PIX_W]) begin
      y_s = '1;
    end else begin
      y_s = rnd_s[PIX_W-1:0];
    end
  end

  // Control delay line and output register; y is blanked when not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) ctrl_r[i] <= '0;
      y_r <= '0;
    end else begin
      ctrl_r[0] <= ctrl_t'{dv: dv_i, hs: hs_i, vs: vs_i};
      for (int i = 1; i < LAT; i++) ctrl_r[i] <= ctrl_r[i-1];
      y_r <= ctrl_r[LAT-2].dv ? y_s : '0;
    end
  end

  assign y_o  = y_r;
  assign dv_o = ctrl_r[LAT-1].dv;
  assign hs_o = ctrl_r[LAT-1].hs;
  assign vs_o = ctrl_r[LAT-1].vs;

endmodule

// File: tb/tb_fir_2d_kernel.sv
// Self-checking bench for fir_2d_kernel: direct-convolution reference model
// over the full input history, table-driven constant frames, corner sequences.
module tb_fir_2d_kernel;

  localparam int MAXN = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        p0, p1, p2, p3, p4;
  logic              dv_i, hs_i, vs_i;
  logic              coef_we;
  logic [4:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic [3:0]        shift_i;
  logic [7:0]        y_o;
  logic              dv_o, hs_o, vs_o;

  fir_2d_kernel #(.COEF_W(8), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .shift_i(shift_i),
    .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int center; int other; int shift; int pix; bit load; int exp_y;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int last_rst = -1;
  int pix_h [MAXN][5];
  bit dv_h [MAXN], hs_h [MAXN], vs_h [MAXN], rst_h [MAXN];
  int act_c_h [MAXN][25];
  int act_s_h [MAXN];
  int yo_h [MAXN];
  bit dvo_h [MAXN];
  int sh_c [25], ac_c [25];
  int sh_s = 0, ac_s = 0;
  bit vs_prev = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One clock: record inputs, advance model, compare all outputs.
  task automatic tick();
    int c, m, v, acc, sh, ey, edv, ehs, evs;
    bit t_we;
    int t_addr, t_data, t_shift;
    if (n >= MAXN) begin
      $display("FAIL history overflow at step %0d", n);
      $fatal(1);
    end
    pix_h[n][0] = int'(p0); pix_h[n][1] = int'(p1); pix_h[n][2] = int'(p2);
    pix_h[n][3] = int'(p3); pix_h[n][4] = int'(p4);
    dv_h[n] = dv_i; hs_h[n] = hs_i; vs_h[n] = vs_i; rst_h[n] = rst;
    t_we = coef_we; t_addr = int'(coef_addr); t_data = int'(coef_data); t_shift = int'(shift_i);
    @(posedge clk); #1;
    if (rst_h[n]) begin
      last_rst = n;
      for (int i = 0; i < 25; i++) begin sh_c[i] = (i == 12) ? 1 : 0; ac_c[i] = sh_c[i]; end
      sh_s = 0; ac_s = 0; vs_prev = 1'b0;
    end else begin
      if (vs_h[n] && !vs_prev) begin
        for (int i = 0; i < 25; i++) ac_c[i] = sh_c[i];
        ac_s = sh_s;
      end
      if (t_we && t_addr < 25) sh_c[t_addr] = t_data;
      sh_s = t_shift;
      vs_prev = vs_h[n];
    end
    for (int i = 0; i < 25; i++) act_c_h[n][i] = ac_c[i];
    act_s_h[n] = ac_s;
    ey = 0; edv = 0; ehs = 0; evs = 0;
    c = n - 6;
    if (!rst_h[n] && c >= 0 && c > last_rst) begin
      edv = dv_h[c]; ehs = hs_h[c]; evs = vs_h[c];
    end
    if (edv != 0) begin
      acc = 0;
      for (int r = 0; r < 5; r++) begin
        for (int j = 0; j < 5; j++) begin
          m = c + 2 - j;
          v = (m >= 0 && m > last_rst) ? pix_h[m][r] : 0;
          acc += act_c_h[c+2][r*5 + j] * v;
        end
      end
      sh = act_s_h[c+5];
      if (sh > 0) acc += 1 << (sh - 1);
      acc = acc >>> sh;
      ey = (acc < 0) ? 0 : (acc > 255) ? 255 : acc;
    end
    yo_h[n] = int'(y_o); dvo_h[n] = dv_o;
    checks++;
    if (y_o !== 8'(ey) || dv_o !== 1'(edv) || hs_o !== 1'(ehs) || vs_o !== 1'(evs)) begin
      errors++;
      $display("FAIL step %0d got y=%0d dv=%0b hs=%0b vs=%0b want y=%0d dv=%0d hs=%0d vs=%0d",
               n, y_o, dv_o, hs_o, vs_o, ey, edv, ehs, evs);
    end
    n++;
  endtask

  task automatic set_col(input int val);
    p0 = 8'(val); p1 = 8'(val); p2 = 8'(val); p3 = 8'(val); p4 = 8'(val);
  endtask

  task automatic idle(input int k);
    set_col(0); dv_i = 1'b0; hs_i = 1'b0;
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic line(input int val, input int ncols, output int s);
    s = n;
    for (int i = 0; i < ncols; i++) begin
      set_col(val); dv_i = 1'b1; hs_i = (i == 0);
      tick();
    end
    idle(8);
  endtask

  task automatic load_coefs(input int center, input int other, input bit dvv, input int val);
    for (int a = 0; a < 25; a++) begin
      coef_we = 1'b1; coef_addr = 5'(a);
      coef_data = 8'((a == 12) ? center : other);
      set_col(val); dv_i = dvv; hs_i = 1'b0;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic vs_pulse(input bit we, input int addr, input int data);
    vs_i = 1'b1; coef_we = we; coef_addr = 5'(addr); coef_data = 8'(data);
    tick();
    coef_we = 1'b0;
    tick();
    vs_i = 1'b0;
    tick();
  endtask

  initial begin
    vec_t tbl [7];
    int s, r0;
    tbl[0] = '{center: 1,  other: 0, shift: 0, pix: 100, load: 1'b0, exp_y: 100};
    tbl[1] = '{center: 1,  other: 1, shift: 0, pix: 10,  load: 1'b1, exp_y: 250};
    tbl[2] = '{center: 1,  other: 1, shift: 0, pix: 11,  load: 1'b1, exp_y: 255};
    tbl[3] = '{center: -1, other: 0, shift: 0, pix: 50,  load: 1'b1, exp_y: 0};
    tbl[4] = '{center: 3,  other: 0, shift: 1, pix: 5,   load: 1'b1, exp_y: 8};
    tbl[5] = '{center: 1,  other: 1, shift: 3, pix: 20,  load: 1'b1, exp_y: 63};
    tbl[6] = '{center: -2, other: 1, shift: 2, pix: 40,  load: 1'b1, exp_y: 220};

    rst = 1'b1; set_col(0); dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    coef_we = 1'b0; coef_addr = 5'd0; coef_data = 8'sd0; shift_i = 4'd0;
    tick(); tick(); tick();
    rst = 1'b0;
    idle(2);

    // Constant frames from the vector table.
    for (int t = 0; t < 7; t++) begin
      if (tbl[t].load) load_coefs(tbl[t].center, tbl[t].other, 1'b0, 0);
      shift_i = 4'(tbl[t].shift);
      idle(2);
      vs_pulse(1'b0, 0, 0);
      line(tbl[t].pix, 12, s);
      chk($sformatf("tbl%0d_interior_y", t), yo_h[s+12], tbl[t].exp_y);
      if (t == 0) begin
        chk("reset_id_first_y", yo_h[s+6], 100);
        chk("reset_id_dv_before", int'(dvo_h[s+5]), 0);
        chk("reset_id_dv_at7", int'(dvo_h[s+6]), 1);
      end
    end

    // Frame-boundary coefficient update.
    shift_i = 4'd0;
    load_coefs(1, 1, 1'b0, 0);
    idle(2);
    vs_pulse(1'b0, 0, 0);
    line(10, 12, s);
    chk("fb_box_before", yo_h[s+12], 250);
    load_coefs(2, 0, 1'b1, 10);
    chk("fb_midframe_write_ignored", yo_h[n-1], 250);
    idle(8);
    vs_pulse(1'b1, 12, 4);
    line(10, 12, s);
    chk("fb_after_vs", yo_h[s+12], 20);
    coef_we = 1'b1; coef_addr = 5'd25; coef_data = 8'sd9; tick();
    coef_addr = 5'd31; tick();
    coef_we = 1'b0;
    idle(2);
    vs_pulse(1'b0, 0, 0);
    line(10, 12, s);
    chk("fb_coincident_next_frame", yo_h[s+12], 40);

    // Border padding: impulse under centre tap, then box at line edges.
    load_coefs(1, 0, 1'b0, 0);
    idle(2);
    vs_pulse(1'b0, 0, 0);
    s = n;
    for (int i = 0; i < 8; i++) begin
      set_col((i == 0) ? 200 : 0); dv_i = 1'b1; hs_i = (i == 0);
      tick();
    end
    idle(8);
    chk("impulse_lat7", yo_h[s+6], 200);
    chk("impulse_next", yo_h[s+7], 0);
    load_coefs(1, 1, 1'b0, 0);
    idle(2);
    vs_pulse(1'b0, 0, 0);
    line(10, 12, s);
    chk("box_left_edge", yo_h[s+6], 150);
    chk("box_left_edge1", yo_h[s+7], 200);
    chk("box_right_edge", yo_h[s+17], 150);

    // Mid-frame reset discards in-flight data.
    for (int i = 0; i < 10; i++) begin
      set_col(30); dv_i = 1'b1; hs_i = (i == 0); tick();
    end
    r0 = n;
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_col(30); dv_i = 1'b1; hs_i = 1'b0; tick();
    end
    idle(8);
    chk("rst_dv_held_low", int'(dvo_h[r0+6]), 0);
    chk("rst_dv_first", int'(dvo_h[r0+7]), 1);
    chk("rst_y_identity", yo_h[r0+7], 30);

    // Randomized frames against the reference model.
    for (int f = 0; f < 3; f++) begin
      shift_i = 4'($urandom_range(0, 10));
      for (int k = 0; k < 20; k++) begin
        coef_we = 1'($urandom_range(0, 1)); coef_addr = 5'($urandom_range(0, 31));
        coef_data = 8'($urandom_range(0, 255));
        idle(1);
      end
      coef_we = 1'b0;
      vs_pulse(1'($urandom_range(0, 1)), $urandom_range(0, 24), $urandom_range(0, 255));
      for (int l = 0; l < 5; l++) begin
        for (int i = 0; i < 16; i++) begin
          p0 = 8'($urandom_range(0, 255)); p1 = 8'($urandom_range(0, 255));
          p2 = 8'($urandom_range(0, 255)); p3 = 8'($urandom_range(0, 255));
          p4 = 8'($urandom_range(0, 255));
          dv_i = ($urandom_range(0, 9) != 0); hs_i = (i == 0);
          coef_we = ($urandom_range(0, 7) == 0); coef_addr = 5'($urandom_range(0, 31));
          coef_data = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 15) == 0) shift_i = 4'($urandom_range(0, 10));
          tick();
        end
        coef_we = 1'b0;
        idle(4);
      end
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_2d_kernel.md
FIR_2D_KERNEL -- requirements
Module: fir_2d_kernel

Interface
REQ-001 SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-002 SHALL have parameter PIX_W, default 8, unsigned pixel width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports p0..p4, input, PIX_W each, one vertical column from the line store; p0 is the oldest row, p4 the current row.
REQ-006 SHALL have ports dv_i / hs_i / vs_i, input, 1 each, control signals aligned with p0..p4.
REQ-007 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-008 SHALL have port coef_addr, input, 5, coefficient index = row*5+col, valid 0..24.
REQ-009 SHALL have port coef_data, input, COEF_W, signed coefficient value.
REQ-010 SHALL have port shift_i, input, 4, right-shift normalisation amount.
REQ-011 SHALL have port y_o, output, PIX_W, filtered pixel.
REQ-012 SHALL have ports dv_o / hs_o / vs_o, output, 1 each, controls aligned with y_o.

Function
REQ-013 SHALL shift the p0..p4 column into a 5x5 window register every clock, with no stall; window column 0 holds the newest column and column 4 the oldest.
REQ-014 SHALL treat pixels as unsigned and zero-extend them to PIX_W+1 bits before the signed multiply; each product SHALL be PIX_W+COEF_W+1 = 17 bits signed.
REQ-015 SHALL accumulate the 25 products at 22 bits signed; overflow SHALL be impossible at this width.
REQ-016 SHALL use this pipeline: window register, then registered products, then 5 registered row sums, then registered total, then the output register.
REQ-017 SHALL form y_o as follows: add 2^(shift-1) when shift>0; arithmetic right-shift by shift; clamp to 0..255.
REQ-018 SHALL centre the output on the window centre pixel, i.e. the column input 2 cycles before window capture; total latency from a column input to its centred y_o SHALL be exactly 7 clocks.
REQ-019 SHALL delay dv_i / hs_i / vs_i by exactly 7 clocks to produce dv_o / hs_o / vs_o.
REQ-020 SHALL NOT treat image borders specially; zeros supplied upstream during blanking SHALL act as padding.
REQ-021 SHALL write coef_data into shadow coefficient register coef_addr on a coef_we cycle.
REQ-022 SHALL sample shift_i into a shadow register every cycle.
REQ-023 SHALL ignore coef_we when coef_addr > 24.
REQ-024 SHALL copy shadow to active coefficients and shift on the rising edge of vs_i (vs_i=1 while previous vs_i=0); the arithmetic SHALL use only active values, so the filter never changes mid-frame.
REQ-025 SHALL, when coef_we and the vs_i rising edge coincide, copy the pre-write shadow to active and land the write in shadow for the next frame.
REQ-026 SHALL zero-drive y_o whenever dv_o=0.

Reset
REQ-027 SHALL, on rst, clear the window, all pipeline registers, the control delay line, y_o, dv_o, hs_o and vs_o to 0.
REQ-028 SHALL, on rst, set shadow and active coefficients to identity (index 12 = 1, all others 0) and shadow and active shift to 0.
REQ-029 SHALL, on rst asserted mid-frame, discard in-flight data; outputs SHALL stay 0 until 7 clocks after the first post-reset input.

Structure
REQ-030 SHALL place KSIZE=5, NTAP=25, CENTER_IDX=12, ACC_W=22 and the latency constant LAT=7 in the shared filter package.
REQ-031 SHALL use one sub-module, fir_row_mac: 5 pixels × 5 coefficients to 1 registered row sum, instantiated 5 times.

Verification
REQ-032 SHALL check reset identity: constant frame of 100 with dv=1 -> y_o=100 from cycle 7, dv_o delayed 7.
REQ-033 SHALL check box blur: all coefficients=1, shift=0, loaded before vs edge, pixels=10 -> interior y_o=250; pixels=11 -> clamp to 255.
REQ-034 SHALL check negative clamp: centre=-1, others 0, pixels=50 -> y_o=0.
REQ-035 SHALL check rounding: centre=3, shift=1, pixel=5 -> (15+1)>>1 = y_o 8.
REQ-036 SHALL check frame-boundary update: coef writes mid-frame -> output unchanged until vs_i rises; write coincident with the vs edge -> applied only after the following vs edge.
REQ-037 SHALL check border padding: single 200 impulse at column 0 under the identity-like centre tap -> y_o=200 at latency 7; box filter -> edge outputs use zeros outside the row.
